// File: rtl/nrisc_pkg.sv
// Shared types and constants for the nRISC data-memory path.
package nrisc_pkg;

  localparam int unsigned LARGURA     = 8;
  localparam int unsigned PROF_PADRAO = 4;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ESCREVENDO = 2'd1,
    LENDO      = 2'd2,
    RETORNO    = 2'd3
  } estado_t;

  typedef struct packed {
    logic [LARGURA-1:0] addr;
    logic [LARGURA-1:0] data;
  } entrada_t;

endpackage

// File: rtl/fila_escrita.sv
// Posted-write FIFO of {addr, data}; with WBUF_FORWARD_EN it also searches
// for the newest entry matching a load address.
module fila_escrita
  import nrisc_pkg::*;
#(
  parameter int unsigned PROF = PROF_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  entrada_t           entrada_i,
  output entrada_t           cabeca_o,
  output entrada_t           proxima_o,
  output logic               cheia_o,
  output logic               mais_de_um_o,
`ifdef WBUF_FORWARD_EN
  input  logic [LARGURA-1:0] busca_addr_i,
  output logic               hit_o,
  output logic [LARGURA-1:0] hit_data_o,
`endif
  output logic               vazia_o
);

  localparam int unsigned PW = $clog2(PROF);
  localparam int unsigned CW = PW + 1;

  entrada_t       mem_q [PROF];
  logic [PW-1:0]  cab_q;
  logic [PW-1:0]  cau_q;
  logic [CW-1:0]  cnt_q;

  // Pointers wrap naturally because PROF is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      cab_q <= '0;
      cau_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) cau_q <= cau_q + PW'(1);
      if (pop_i)  cab_q <= cab_q + PW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[cau_q] <= entrada_i;
  end

  assign cabeca_o     = mem_q[cab_q];
  assign proxima_o    = mem_q[cab_q + PW'(1)];
  assign cheia_o      = (cnt_q == CW'(PROF));
  assign vazia_o      = (cnt_q == '0);
  assign mais_de_um_o = (cnt_q > CW'(1));

`ifdef WBUF_FORWARD_EN
  // Walk oldest to newest so the last match found is the newest store.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int unsigned k = 0; k < PROF; k++) begin
      if ((CW'(k) < cnt_q) && (mem_q[cab_q + PW'(k)].addr == busca_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[cab_q + PW'(k)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/controlador_memoria_dados.sv
// Data-memory controller: posted-write buffer drained over req/ack, blocking
// external reads, stall to the core. Macro WBUF_FORWARD_EN enables load forwarding.
module controlador_memoria_dados
  import nrisc_pkg::*;
#(
  parameter int unsigned PROF = PROF_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               MemWrite,
  input  logic               MemLoad,
  input  logic [LARGURA-1:0] enderecoDado,
  input  logic [LARGURA-1:0] dadoEscr,
  output logic [LARGURA-1:0] dadoLido,
  output logic               stall,
  output logic               buffer_vazio,
  output logic               mem_req,
  output logic               mem_we,
  output logic [LARGURA-1:0] mem_addr,
  output logic [LARGURA-1:0] mem_wdata,
  input  logic [LARGURA-1:0] mem_rdata,
  input  logic               mem_ack
);

  estado_t            estado_q, estado_d;
  logic               req_q, req_d, we_q, we_d;
  logic [LARGURA-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [LARGURA-1:0] leitura_q, leitura_d;
  entrada_t           nova, cabeca, proxima;
  logic               cheia, vazia, mais_de_um;
  logic               store, load, push, pop, carga_miss, carga_ext;
`ifdef WBUF_FORWARD_EN
  logic               hit;
  logic [LARGURA-1:0] hit_data;
`endif

  // A simultaneous store and load is handled as a store.
  assign store = MemWrite;
  assign load  = MemLoad & ~MemWrite;
  assign pop   = (estado_q == ESCREVENDO) & mem_ack;
  assign push  = store & (~cheia | pop);
  assign nova  = '{addr: enderecoDado, data: dadoEscr};

`ifdef WBUF_FORWARD_EN
  assign carga_miss = load & ~hit;
  assign carga_ext  = carga_miss;
  assign dadoLido   = (load & hit) ? hit_data : leitura_q;
`else
  // Without forwarding a load may only go out once every older store has drained.
  assign carga_miss = load;
  assign carga_ext  = load & vazia;
  assign dadoLido   = leitura_q;
`endif

  fila_escrita #(.PROF(PROF)) u_fila (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .entrada_i    (nova),
    .cabeca_o     (cabeca),
    .proxima_o    (proxima),
    .cheia_o      (cheia),
    .mais_de_um_o (mais_de_um),
`ifdef WBUF_FORWARD_EN
    .busca_addr_i (enderecoDado),
    .hit_o        (hit),
    .hit_data_o   (hit_data),
`endif
    .vazia_o      (vazia)
  );

  always_ff @(posedge clock) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  // Next state: in OCIOSO a load miss wins over draining.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: begin
        if (carga_ext)   estado_d = LENDO;
        else if (!vazia) estado_d = ESCREVENDO;
      end
      ESCREVENDO: begin
        if (mem_ack) estado_d = (mais_de_um && !carga_ext) ? ESCREVENDO : OCIOSO;
      end
      LENDO: begin
        if (mem_ack) estado_d = RETORNO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Handshake register next values and the combinational stall.
  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    leitura_d = leitura_q;
    stall     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (estado_d == LENDO) begin
          req_d = 1'b1; we_d = 1'b0; addr_d = enderecoDado; wdata_d = '0;
        end else if (estado_d == ESCREVENDO) begin
          req_d = 1'b1; we_d = 1'b1; addr_d = cabeca.addr; wdata_d = cabeca.data;
        end
      end
      ESCREVENDO: begin
        if (mem_ack && estado_d == ESCREVENDO) begin
          addr_d = proxima.addr; wdata_d = proxima.data;
        end else if (mem_ack) begin
          req_d = 1'b0; we_d = 1'b0; addr_d = '0; wdata_d = '0;
        end
      end
      LENDO: begin
        if (mem_ack) begin
          leitura_d = mem_rdata;
          req_d = 1'b0; we_d = 1'b0; addr_d = '0; wdata_d = '0;
        end
      end
      default: ;
    endcase
    if (store)                                 stall = cheia & ~pop;
    else if (carga_miss && estado_q != RETORNO) stall = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      leitura_q <= '0;
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      leitura_q <= leitura_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign buffer_vazio = vazia;

endmodule

// File: tb/tb_controlador_memoria_dados.sv
// Directed bench for controlador_memoria_dados with a latency-programmable memory model.
module tb_controlador_memoria_dados;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       MemWrite = 1'b0, MemLoad = 1'b0;
  logic [7:0] enderecoDado = '0, dadoEscr = '0;
  logic [7:0] dadoLido, mem_addr, mem_wdata, mem_rdata;
  logic       stall, buffer_vazio, mem_req, mem_we, mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  int         lat = 2;
  int         cnt = 0;
  logic       ack_en = 1'b1;
  logic       ack_force = 1'b0;
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;
  logic [7:0] mem_model [256];
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];
  int         rd_req_ciclos = 0;

  controlador_memoria_dados #(.PROF(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemLoad      (MemLoad),
    .enderecoDado (enderecoDado),
    .dadoEscr     (dadoEscr),
    .dadoLido     (dadoLido),
    .stall        (stall),
    .buffer_vazio (buffer_vazio),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clock = ~clock;

  // Ack lands in the lat-th cycle that mem_req is high.
  assign mem_ack   = ack_force | (ack_en && mem_req && (cnt == lat - 1));
  assign mem_rdata = mem_model[mem_addr];

  always @(posedge clock) begin
    if (mem_req && !mem_ack && ack_en) cnt <= cnt + 1;
    else                               cnt <= 0;
    if (mem_req && !mem_we) rd_req_ciclos <= rd_req_ciclos + 1;
    if (mem_req && mem_ack && mem_we) begin
      mem_model[mem_addr] <= mem_wdata;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (pre_we) mem_model[pre_addr] <= pre_data;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", mem_wdata); end
    checks++; if (dadoLido !== 8'h00) begin errors++; $display("FAIL reset_dadoLido got %h exp 00", dadoLido); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (buffer_vazio !== 1'b1) begin errors++; $display("FAIL reset_vazio got %b exp 1", buffer_vazio); end
  endtask

  task automatic test_store_single();
    int base;
    int n;
    base = log_addr.size();
    lat = 2; ack_en = 1'b1;
    @(negedge clock);
    MemWrite = 1'b1; enderecoDado = 8'h10; dadoEscr = 8'hAB; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall got %b exp 0", stall); end
    @(negedge clock);
    MemWrite = 1'b0; #1;
    checks++; if (buffer_vazio !== 1'b0) begin errors++; $display("FAIL store_buffered got %b exp 0", buffer_vazio); end
    n = 0;
    while (!buffer_vazio && n < 30) begin @(negedge clock); #1; n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL store_drain_timeout got %0d cycles exp <30", n); end
    checks++; if (log_addr.size() !== base + 1) begin errors++; $display("FAIL store_count got %0d exp %0d", log_addr.size() - base, 1); end
    else begin
      checks++; if (log_addr[base] !== 8'h10) begin errors++; $display("FAIL store_addr got %h exp 10", log_addr[base]); end
      checks++; if (log_data[base] !== 8'hAB) begin errors++; $display("FAIL store_data got %h exp ab", log_data[base]); end
    end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL store_req_idle got %b exp 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    base = log_addr.size();
    ack_en = 1'b0; lat = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      MemWrite = 1'b1; enderecoDado = 8'(8'h40 + i); dadoEscr = 8'(8'hA0 + i); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d got %b exp 0", i, stall); end
    end
    @(negedge clock);
    enderecoDado = 8'h44; dadoEscr = 8'hA4; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_full_stall got %b exp 1", stall); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_hold_stall got %b exp 1", stall); end
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h40, 8'hA0}) begin
        errors++; $display("FAIL b2b_hold_bus got %b%b %h %h exp 11 40 a0", mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    @(negedge clock);
    ack_en = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_push_on_ack got %b exp 0", stall); end
    @(negedge clock);
    MemWrite = 1'b0;
    n = 0;
    #1;
    while (!buffer_vazio && n < 40) begin @(negedge clock); #1; n++; end
    checks++; if (n >= 40) begin errors++; $display("FAIL b2b_drain_timeout got %0d cycles exp <40", n); end
    checks++; if (log_addr.size() !== base + 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", log_addr.size() - base); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_addr[base+i] !== 8'(8'h40 + i) || log_data[base+i] !== 8'(8'hA0 + i)) begin
          errors++; $display("FAIL b2b_order_%0d got %h/%h exp %h/%h", i, log_addr[base+i], log_data[base+i], 8'(8'h40 + i), 8'(8'hA0 + i));
        end
      end
    end
  endtask

`ifdef WBUF_FORWARD_EN
  task automatic test_forward();
    int rd0;
    int n;
    ack_en = 1'b0; lat = 1;
    rd0 = rd_req_ciclos;
    @(negedge clock); MemWrite = 1'b1; enderecoDado = 8'h20; dadoEscr = 8'h11;
    @(negedge clock); dadoEscr = 8'h22;
    @(negedge clock); MemWrite = 1'b0; MemLoad = 1'b1; enderecoDado = 8'h20; #1;
    checks++; if (dadoLido !== 8'h22) begin errors++; $display("FAIL fwd_data got %h exp 22", dadoLido); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_stall got %b exp 0", stall); end
    @(negedge clock); MemLoad = 1'b0;
    checks++; if (rd_req_ciclos !== rd0) begin errors++; $display("FAIL fwd_no_read got %0d exp %0d", rd_req_ciclos, rd0); end
    ack_en = 1'b1;
    n = 0; #1;
    while (!buffer_vazio && n < 30) begin @(negedge clock); #1; n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL fwd_drain_timeout got %0d exp <30", n); end
  endtask
`else
  task automatic test_ordered_load();
    int n;
    ack_en = 1'b0; lat = 1;
    @(negedge clock); MemWrite = 1'b1; enderecoDado = 8'h20; dadoEscr = 8'h22;
    @(negedge clock); MemWrite = 1'b0; MemLoad = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ord_stall got %b exp 1", stall); end
    @(negedge clock); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ord_stall_hold got %b exp 1", stall); end
    @(negedge clock); ack_en = 1'b1;
    n = 0; #1;
    while (stall && n < 30) begin @(negedge clock); #1; n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL ord_timeout got %0d exp <30", n); end
    checks++; if (dadoLido !== 8'h22) begin errors++; $display("FAIL ord_data got %h exp 22", dadoLido); end
    @(negedge clock); MemLoad = 1'b0;
  endtask
`endif

  task automatic test_load_miss();
    int nst;
    int n;
    ack_en = 1'b1; lat = 3;
    @(negedge clock); pre_we = 1'b1; pre_addr = 8'h30; pre_data = 8'h5C;
    @(negedge clock); pre_we = 1'b0;
    MemLoad = 1'b1; enderecoDado = 8'h30; #1;
    checks++; if ({stall, mem_req} !== 2'b10) begin errors++; $display("FAIL miss_first got stall=%b req=%b exp 1 0", stall, mem_req); end
    nst = stall ? 1 : 0;
    @(negedge clock); #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h30}) begin
      errors++; $display("FAIL miss_req got %b%b %h exp 10 30", mem_req, mem_we, mem_addr);
    end
    n = 0;
    while (stall && n < 20) begin nst++; @(negedge clock); #1; n++; end
    checks++; if (nst !== 4) begin errors++; $display("FAIL miss_stall_cycles got %0d exp 4", nst); end
    checks++; if (dadoLido !== 8'h5C) begin errors++; $display("FAIL miss_data got %h exp 5c", dadoLido); end
    @(negedge clock); MemLoad = 1'b0; #1;
    checks++; if ({stall, mem_req, dadoLido} !== {1'b0, 1'b0, 8'h5C}) begin
      errors++; $display("FAIL miss_after got %b %b %h exp 0 0 5c", stall, mem_req, dadoLido);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = log_addr.size();
    ack_en = 1'b0;
    @(negedge clock); MemWrite = 1'b1; enderecoDado = 8'h55; dadoEscr = 8'h66;
    @(negedge clock); MemWrite = 1'b0;
    @(negedge clock); #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 8'h55}) begin
      errors++; $display("FAIL rmid_pending got %b%b %h exp 11 55", mem_req, mem_we, mem_addr);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    checks++; if ({mem_req, buffer_vazio, stall} !== 3'b010) begin
      errors++; $display("FAIL rmid_reset got req=%b vazio=%b stall=%b exp 0 1 0", mem_req, buffer_vazio, stall);
    end
    reset = 1'b0; ack_force = 1'b1;
    @(negedge clock); ack_force = 1'b0; #1;
    checks++; if ({mem_req, buffer_vazio, dadoLido} !== {1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL rmid_late_ack got req=%b vazio=%b data=%h exp 0 1 00", mem_req, buffer_vazio, dadoLido);
    end
    @(negedge clock); #1;
    checks++; if (mem_req !== 1'b0 || log_addr.size() !== base) begin
      errors++; $display("FAIL rmid_idle got req=%b writes=%0d exp 0 0", mem_req, log_addr.size() - base);
    end
    ack_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_store_single();
    test_back_to_back();
`ifdef WBUF_FORWARD_EN
    test_forward();
`else
    test_ordered_load();
`endif
    test_load_miss();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/controlador_memoria_dados.md
# controlador_memoria_dados

Data-memory controller that sits directly downstream of the nRISC core's memory port and consumes its store/load requests. It absorbs stores into a small posted-write buffer and drains them to a slower external data memory over a req/ack handshake. It serves loads either by forwarding from the buffer or by a blocking external read. It drives a `stall` signal back to the core, which the core gates into its PC write enable.

## Interface
Parameters:
- `PROF`, default 4 — write-buffer depth in entries; power of two, ≥2.

Ports:
- `clock` in 1 — single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `MemWrite` in 1 — core store request for the current instruction.
- `MemLoad` in 1 — core load request for the current instruction.
- `enderecoDado` in 8 — byte address from the core.
- `dadoEscr` in 8 — store data from the core.
- `dadoLido` out 8 — load data to the core.
- `stall` out 1 — core must hold PC and the current instruction.
- `buffer_vazio` out 1 — write buffer holds no entries.
- `mem_req` out 1 — external request valid.
- `mem_we` out 1 — 1 = write, 0 = read.
- `mem_addr` out 8 — external address.
- `mem_wdata` out 8 — external write data.
- `mem_rdata` in 8 — external read data, valid with `mem_ack` on reads.
- `mem_ack` in 1 — external completion, one cycle per request.

## Operation
- Write buffer: circular FIFO of {addr, data}, head/tail pointers mod `PROF`, count 0..`PROF`.
- States: OCIOSO, ESCREVENDO, LENDO, RETORNO.
- Store, `MemWrite`=1:
  - If count<`PROF` (or a pop happens this cycle), push `{enderecoDado, dadoEscr}`; `stall`=0.
  - Else `stall`=1 until space exists.
- `MemWrite`=`MemLoad`=1: treated as a store; `MemLoad` is ignored.
- Load hit, `MemLoad`=1 with an address match in the buffer (forwarding enabled): `dadoLido` = data of the newest matching entry, combinationally; `stall`=0; no external access.
- Load miss in OCIOSO:
  - `stall`=1 combinationally.
  - Next state LENDO: `mem_req`=1, `mem_we`=0, `mem_addr`=`enderecoDado`.
  - On `mem_ack`, latch `mem_rdata` into the read register and go to RETORNO.
  - RETORNO: `dadoLido` = read register, `stall`=0; then go to OCIOSO.
- Load miss during ESCREVENDO: `stall`=1; the load starts only after the write completes.
- Drain: in OCIOSO with count>0 and no pending load miss, go to ESCREVENDO with head entry, `mem_we`=1. On `mem_ack`, pop head; go to OCIOSO, or stay in ESCREVENDO with the next head if count>1 and no load is waiting.
- Priority in OCIOSO: load miss > drain.
- Push and pop in the same cycle leave count unchanged.
- `dadoLido` when not forwarding = read register. Read register is updated only on read ack.
- `buffer_vazio` = (count==0).

## Timing
- Reset values:
  - State OCIOSO; pointers and count 0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` all 0.
  - Read register 0, so `dadoLido`=0.
  - `stall`=0; `buffer_vazio`=1.
- Reset mid-transaction abandons the outstanding request; buffered writes are discarded.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered.
  - They stay stable while `mem_req`=1 until the cycle `mem_ack`=1.
  - `mem_ack` is ignored while `mem_req`=0.
- Store with space: 0 stall cycles.
- Hit load: 0 stall cycles.
- Miss load from OCIOSO: 1 cycle to issue + N cycles to ack + 1 RETORNO cycle. `stall` is high for N+1 cycles with an N-cycle memory (N≥1).
- Full buffer: store stalls until the cycle of a drain ack, then pushes in that same cycle.

## Configuration
- Macro `WBUF_FORWARD_EN`.
- Defined: buffer address compare active; hits forward as above; misses bypass buffered writes.
- Undefined: no compare logic. Every load stalls until `buffer_vazio`=1, then performs the external read, which preserves memory ordering.

## Structure
- Shared package `nrisc_pkg`:
  - State encoding constants OCIOSO/ESCREVENDO/LENDO/RETORNO (2 bits).
  - Default `PROF`.
  - 8-bit data/address width constant.
- Sub-module `fila_escrita`: FIFO storage, pointers, count, full/empty, and (under `WBUF_FORWARD_EN`) the newest-match search returning hit + data.
- FSM and handshake stay in the top.

## Test plan
- Reset, then idle → all outputs 0, `buffer_vazio`=1, `stall`=0.
- Store 0x10←0xAB with `mem_ack` 2 cycles after req → no stall. Exactly one write req with addr 0x10, data 0xAB. `buffer_vazio` returns to 1.
- Five back-to-back stores, `PROF`=4, `mem_ack` held 0 → 5th store `stall`=1. Release ack → 5th store pushes in the ack cycle; writes appear in program order.
- With `WBUF_FORWARD_EN`: store 0x20←0x11, then 0x20←0x22, then load 0x20 before drain → `dadoLido`=0x22, `stall`=0, no read req.
- Load 0x30 miss, memory returns 0x5C after 3 cycles → `stall` high 4 cycles, `dadoLido`=0x5C in RETORNO, then `stall`=0.
- Reset asserted while `mem_req`=1 (write) → next cycle `mem_req`=0, count 0, state OCIOSO; late `mem_ack` ignored.
